// File: rtl/doppler_ramp_ctrl.sv
// rtl/doppler_ramp_ctrl.sv - Doppler frequency ramp controller driving the NCO phase-increment word
module doppler_ramp_ctrl #(
    parameter int FREQ_W     = 32,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FREQ_W-1:0]     cmd_target,
    input  logic [FREQ_W-1:0]     cmd_step,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic                  cmd_immediate,
    output logic [FREQ_W-1:0]     freq,
    output logic                  nco_enable,
    output logic                  ramping,
    output logic                  done
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t                state_q, state_d;
    logic [FREQ_W-1:0]     freq_d;
    logic [FREQ_W-1:0]     target_q, target_d;
    logic [FREQ_W-1:0]     step_q, step_d;
    logic [INTERVAL_W-1:0] reload_q, reload_d;
    logic [INTERVAL_W-1:0] count_q, count_d;
    logic                  done_d;
    logic                  nco_enable_d;

    logic                  accept;
    logic                  load_now;
    logic [INTERVAL_W-1:0] cmd_reload;
    logic [FREQ_W:0]       diff;
    logic [FREQ_W:0]       abs_diff;
    logic                  within_step;

    assign cmd_ready = ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign ramping   = (state_q == RAMP);
    assign load_now  = cmd_immediate | (cmd_step == '0) | (cmd_target == freq);
    assign cmd_reload = (cmd_interval == '0) ? '0 : cmd_interval - INTERVAL_W'(1);

    // One extra bit keeps target - freq from wrapping across the signed range.
    assign diff        = {target_q[FREQ_W-1], target_q} - {freq[FREQ_W-1], freq};
    assign abs_diff    = diff[FREQ_W] ? (~diff + (FREQ_W+1)'(1)) : diff;
    assign within_step = abs_diff <= {1'b0, step_q};

    always_comb begin
        state_d      = state_q;
        freq_d       = freq;
        target_d     = target_q;
        step_d       = step_q;
        reload_d     = reload_q;
        count_d      = count_q;
        done_d       = 1'b0;
        nco_enable_d = nco_enable;

        if (accept) begin
            // A new command pre-empts any update scheduled on this edge.
            nco_enable_d = 1'b1;
            if (load_now) begin
                freq_d  = cmd_target;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                target_d = cmd_target;
                step_d   = cmd_step;
                reload_d = cmd_reload;
                count_d  = cmd_reload;
                state_d  = RAMP;
            end
        end else if (state_q == RAMP) begin
            if (count_q == '0) begin
                count_d = reload_q;
                if (within_step) begin
                    freq_d  = target_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (diff[FREQ_W]) begin
                    freq_d = freq - step_q;
                end else begin
                    freq_d = freq + step_q;
                end
            end else begin
                count_d = count_q - INTERVAL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            freq       <= '0;
            target_q   <= '0;
            step_q     <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            done       <= 1'b0;
            nco_enable <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq       <= freq_d;
            target_q   <= target_d;
            step_q     <= step_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            done       <= done_d;
            nco_enable <= nco_enable_d;
        end
    end

endmodule

// File: tb/tb_doppler_ramp_ctrl.sv
// tb/tb_doppler_ramp_ctrl.sv - scoreboard bench for doppler_ramp_ctrl against a trajectory model
module tb_doppler_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_target = '0;
    logic [31:0] cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic        cmd_immediate = 1'b0;
    logic [31:0] freq;
    logic        nco_enable;
    logic        ramping;
    logic        done;

    doppler_ramp_ctrl #(.FREQ_W(32), .INTERVAL_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_interval(cmd_interval),
        .cmd_immediate(cmd_immediate), .freq(freq), .nco_enable(nco_enable),
        .ramping(ramping), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] f;
        bit          d;
        bit          r;
    } ev_t;

    ev_t         expq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    longint      m_freq = 0;
    logic [31:0] last_freq = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input longint f, input bit d, input bit r);
        ev_t e;
        e.cyc = c;
        e.f   = f[31:0];
        e.d   = d;
        e.r   = r;
        expq.push_back(e);
    endtask

    // Monitor: every visible output event (freq change or done pulse) consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (freq != last_freq || done)) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: freq=0x%0h done=%0d at cycle %0d", freq, done, cyc);
            end else begin
                ev_t e;
                e = expq.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("freq", freq, e.f);
                check("done", done, e.d);
                check("ramping", ramping, e.r);
            end
        end
        last_freq = freq;
    end

    // Issue one command; the next command (or reset) lands exactly `gap` edges later.
    task automatic send(input logic [31:0] t, input logic [31:0] s, input logic [15:0] iv,
                        input bit imm, input int gap);
        int     k, kn, n, c;
        longint f, tt, st, d, ad;
        k  = cyc + 1;
        kn = k + gap;
        f  = m_freq;
        tt = longint'($signed(t));
        st = longint'(s);
        n  = (iv == 0) ? 1 : int'(iv);
        if (imm || s == 0 || tt == f) begin
            f = tt;
            push(k, f, 1'b1, 1'b0);
        end else begin
            c = k;
            while (1) begin
                c += n;
                if (c >= kn) break;
                d  = tt - f;
                ad = (d < 0) ? -d : d;
                if (ad <= st) begin
                    f = tt;
                    push(c, f, 1'b1, 1'b0);
                    break;
                end
                f += (d > 0) ? st : -st;
                push(c, f, 1'b0, 1'b1);
            end
        end
        m_freq = f;

        cmd_valid     = 1'b1;
        cmd_target    = t;
        cmd_step      = s;
        cmd_interval  = iv;
        cmd_immediate = imm;
        check("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid     = 1'b0;
        cmd_target    = $urandom;
        cmd_step      = $urandom;
        cmd_interval  = 16'($urandom);
        cmd_immediate = 1'($urandom);
        check("nco_enable", nco_enable, 1);
        for (int i = 1; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_freq", freq, 0);
            check("rst_nco_enable", nco_enable, 0);
            check("rst_ramping", ramping, 0);
            check("rst_done", done, 0);
            check("rst_cmd_ready", cmd_ready, 0);
        end
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);
        m_freq = 0;
    endtask

    initial begin
        logic [31:0] t, s;
        logic [15:0] iv;
        bit          imm;
        #1;
        do_reset();

        send(32'h0001_0000, 32'd0, 16'd0, 1'b1, 3);
        send(32'd0, 32'd0, 16'd0, 1'b1, 3);
        send(32'd100, 32'd30, 16'd4, 1'b0, 20);
        send(32'hFFFF_FFCE, 32'd60, 16'd0, 1'b0, 6);
        send(32'd0, 32'd0, 16'd0, 1'b1, 3);
        send(32'd100, 32'd30, 16'd4, 1'b0, 6);
        send(32'd0, 32'd30, 16'd4, 1'b0, 12);
        send(32'h7FFF_FFFF, 32'd0, 16'd0, 1'b1, 3);
        send(32'h8000_0000, 32'hFFFF_FFFF, 16'd0, 1'b0, 4);
        send(32'h8000_0000, 32'd5, 16'd2, 1'b0, 4);

        for (int i = 0; i < 150; i++) begin
            t   = 32'($urandom_range(0, 4000)) - 32'd2000;
            s   = 32'($urandom_range(1, 300));
            iv  = 16'($urandom_range(0, 6));
            imm = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0: s = 32'd0;
                1: t = m_freq[31:0];
                2: s = $urandom;
                default: ;
            endcase
            send(t, s, iv, imm, $urandom_range(1, 40));
        end

        send(32'd1000, 32'd10, 16'd3, 1'b0, 20);
        do_reset();
        send(32'hFFFF_FF00, 32'd64, 16'd1, 1'b0, 12);
        send(32'd7, 32'd0, 16'd0, 1'b1, 4);

        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
